parity_accum: RTL

PARITY_ACCUM -- requirements
Module: parity_accum

---
 rtl/parity_accum_pkg.sv | 12 +
 rtl/parity_reduce.sv | 12 +
 rtl/parity_accum.sv | 91 +++++++++
 3 files changed

// File: rtl/parity_accum_pkg.sv
// Shared types and constants for the parity accumulator.
package parity_accum_pkg;

  localparam int unsigned COUNT_W = 16;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StAccum = 2'd1,
    StHold  = 2'd2
  } state_e;

endpackage

// File: rtl/parity_reduce.sv
// Combinational masked XOR reduction of a single data word.
module parity_reduce #(
  parameter int unsigned      WIDTH = 9,
  parameter logic [WIDTH-1:0] MASK  = '1
) (
  input  logic [WIDTH-1:0] word,
  output logic             parity
);

  assign parity = ^(word & MASK);

endmodule

// File: rtl/parity_accum.sv
// Frame parity accumulator: XORs per-word masked parities over a frame and holds the result.
// Optional word counter enabled by defining PARITY_ACCUM_COUNT_EN.
module parity_accum #(
  parameter int unsigned      WIDTH = 9,
  parameter logic [WIDTH-1:0] MASK  = '1,
  parameter bit               ODD   = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_parity,
  output logic [15:0]      out_count
);
  import parity_accum_pkg::*;

  state_e state;
  logic   acc;
  logic   word_par;
  logic   accept;

  parity_reduce #(
    .WIDTH (WIDTH),
    .MASK  (MASK)
  ) u_reduce (
    .word   (in_data),
    .parity (word_par)
  );

  // Handshake signals depend on state only, never on in_valid.
  assign in_ready  = (state != StHold);
  assign out_valid = (state == StHold);
  assign accept    = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= StIdle;
      acc        <= 1'b0;
      out_parity <= 1'b0;
    end else begin
      unique case (state)
        StIdle, StAccum: begin
          if (accept) begin
            acc <= acc ^ word_par;
            if (in_last) begin
              state      <= StHold;
              out_parity <= acc ^ word_par ^ ODD;
            end else begin
              state <= StAccum;
            end
          end
        end
        StHold: begin
          // Clearing here guarantees nothing carries into the next frame.
          if (out_ready) begin
            state      <= StIdle;
            acc        <= 1'b0;
            out_parity <= 1'b0;
          end
        end
        default: begin
          state <= StIdle;
          acc   <= 1'b0;
        end
      endcase
    end
  end

`ifdef PARITY_ACCUM_COUNT_EN
  logic [COUNT_W-1:0] count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (state == StHold) begin
      if (out_ready) count_q <= '0;
    end else if (accept && (count_q != '1)) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign out_count = count_q;
`else
  assign out_count = 16'h0000;
`endif

endmodule
